// File: rtl/wb_stage_pipe.sv
// rtl/wb_stage_pipe.sv - RISC-V writeback stage with load-wait FSM; optional WB_RETIRE_CNT_EN retire counter
module wb_stage_pipe #(
    parameter int XLEN         = 32,
    parameter int RADDR_W      = 5,
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               valid_m,
    input  logic               reg_write_m,
    input  logic [1:0]         result_src_m,
    input  logic [2:0]         funct3_m,
    input  logic [XLEN-1:0]    alu_result_m,
    input  logic [XLEN-1:0]    pc_plus4_m,
    input  logic [XLEN-1:0]    imm_m,
    input  logic [RADDR_W-1:0] rd_m,
    input  logic [XLEN-1:0]    rdata_i,
    input  logic               rdata_valid_i,
    output logic               reg_write_w,
    output logic [RADDR_W-1:0] rd_w,
    output logic [XLEN-1:0]    result_w,
    output logic               busy_o,
    output logic               load_err_o
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]        retire_cnt_o
`endif
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t             r_state, w_state_nxt;
    logic [7:0]         r_cnt, w_cnt_nxt;
    logic               r_valid, r_reg_write, r_done;
    logic [1:0]         r_src;
    logic [2:0]         r_funct3;
    logic [XLEN-1:0]    r_alu, r_pc4, r_imm, r_ldata;
    logic [RADDR_W-1:0] r_rd;

    logic               w_need, w_timeout, w_abort, w_complete, w_capture, w_clear;
    logic [2:0]         w_off;
    logic [7:0]         w_b;
    logic [15:0]        w_h;
    logic [31:0]        w_wd;
    logic [XLEN-1:0]    w_ext;

    // r_done marks a held instruction that already completed, so a stalled
    // load re-presents its latched data instead of waiting on memory again.
    assign w_need     = r_valid & (r_src == 2'b01) & ~r_done;
    assign w_timeout  = (r_state == S_WAIT) & w_need & ~rdata_valid_i
                        & (r_cnt == 8'(LOAD_TIMEOUT - 1));
    assign w_abort    = (r_state == S_WAIT) & flush_i;
    assign w_complete = r_valid & (~w_need | rdata_valid_i) & ~w_abort;

    assign busy_o      = w_need & ~rdata_valid_i & ~w_timeout;
    assign load_err_o  = w_timeout & ~flush_i;
    assign reg_write_w = w_complete & r_reg_write & (r_rd != '0);
    assign rd_w        = r_rd;

    assign w_capture = ~busy_o & ~stall_i;
    assign w_clear   = flush_i | (~w_capture & w_timeout);

    assign w_off = (XLEN == 64) ? r_alu[2:0] : {1'b0, r_alu[1:0]};
    assign w_b   = 8'(rdata_i >> {w_off, 3'b000});
    assign w_h   = 16'(rdata_i >> {w_off[2:1], 4'b0000});
    assign w_wd  = 32'(rdata_i >> {w_off[2], 5'b00000});

    always_comb begin
        w_ext = '0;
        case (r_funct3)
            3'b000:  w_ext = XLEN'($signed(w_b));
            3'b001:  w_ext = XLEN'($signed(w_h));
            3'b010:  w_ext = XLEN'($signed(w_wd));
            3'b100:  w_ext = XLEN'(w_b);
            3'b101:  w_ext = XLEN'(w_h);
            3'b110:  w_ext = (XLEN == 64) ? XLEN'(w_wd) : '0;
            3'b011:  w_ext = (XLEN == 64) ? rdata_i : '0;
            default: w_ext = '0;
        endcase
    end

    always_comb begin
        result_w = r_imm;
        case (r_src)
            2'b00:   result_w = r_alu;
            2'b01:   result_w = r_done ? r_ldata : w_ext;
            2'b10:   result_w = r_pc4;
            default: result_w = r_imm;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_need && !rdata_valid_i && !flush_i) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            S_WAIT: begin
                if (flush_i || rdata_valid_i || w_timeout || !w_need) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_done      <= 1'b0;
            r_src       <= '0;
            r_funct3    <= '0;
            r_alu       <= '0;
            r_pc4       <= '0;
            r_imm       <= '0;
            r_rd        <= '0;
            r_ldata     <= '0;
        end else if (w_clear) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_done      <= 1'b0;
            r_src       <= '0;
            r_funct3    <= '0;
            r_alu       <= '0;
            r_pc4       <= '0;
            r_imm       <= '0;
            r_rd        <= '0;
        end else if (w_capture) begin
            r_valid     <= valid_m;
            r_reg_write <= reg_write_m;
            r_done      <= 1'b0;
            r_src       <= result_src_m;
            r_funct3    <= funct3_m;
            r_alu       <= alu_result_m;
            r_pc4       <= pc_plus4_m;
            r_imm       <= imm_m;
            r_rd        <= rd_m;
        end else if (w_complete && !r_done) begin
            r_done  <= 1'b1;
            r_ldata <= w_ext;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] r_retire_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= '0;
        end else if (w_complete && !r_done) begin
            r_retire_cnt <= r_retire_cnt + 64'd1;
        end
    end

    assign retire_cnt_o = r_retire_cnt;
`else
    // No retire counter state in this build.
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// tb/tb_wb_stage_pipe.sv - self-checking bench for wb_stage_pipe with a behavioural model
module tb_wb_stage_pipe;
    localparam int XLEN = 32;
    localparam int RADDR_W = 5;
    localparam int LT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 0, flush_i = 0, valid_m = 0, reg_write_m = 0, rdata_valid_i = 0;
    logic [1:0]  result_src_m = '0;
    logic [2:0]  funct3_m = '0;
    logic [31:0] alu_result_m = '0, pc_plus4_m = '0, imm_m = '0, rdata_i = '0;
    logic [4:0]  rd_m = '0;
    logic        reg_write_w, busy_o, load_err_o;
    logic [4:0]  rd_w;
    logic [31:0] result_w;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt_o;
`endif

    always #5 clk = ~clk;

    wb_stage_pipe #(.XLEN(XLEN), .RADDR_W(RADDR_W), .LOAD_TIMEOUT(LT)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .valid_m(valid_m), .reg_write_m(reg_write_m), .result_src_m(result_src_m),
        .funct3_m(funct3_m), .alu_result_m(alu_result_m), .pc_plus4_m(pc_plus4_m),
        .imm_m(imm_m), .rd_m(rd_m), .rdata_i(rdata_i), .rdata_valid_i(rdata_valid_i),
        .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
        .busy_o(busy_o), .load_err_o(load_err_o)
`ifdef WB_RETIRE_CNT_EN
        , .retire_cnt_o(retire_cnt_o)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Model of the instruction sitting in WB and how long it has waited for data.
    logic        m_valid, m_rw, m_done;
    logic [1:0]  m_src;
    logic [2:0]  m_f3;
    logic [31:0] m_alu, m_pc4, m_imm, m_ldata;
    logic [4:0]  m_rd;
    int          m_waited;
    longint unsigned m_retired = 0;

    bit          e_need, e_timeout, e_complete, e_busy, e_err, e_wr, e_res_chk;
    logic [31:0] e_res;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] data);
        int unsigned off, b, h;
        off = addr % 4;
        b = (data >> (8 * off)) % 256;
        h = (data >> (16 * (off / 2))) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd2:    return data;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_clear();
        m_valid = 0; m_rw = 0; m_done = 0; m_src = 0; m_f3 = 0;
        m_alu = 0; m_pc4 = 0; m_imm = 0; m_rd = 0; m_waited = 0;
    endtask

    task automatic set_m(input logic v, input logic rw, input logic [1:0] src, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] pc4, input logic [4:0] rd);
        valid_m = v; reg_write_m = rw; result_src_m = src; funct3_m = f3;
        alu_result_m = alu; pc_plus4_m = pc4; imm_m = 32'hABCD_0000; rd_m = rd;
    endtask

    task automatic eval();
        bit abort;
        #1;
        e_need     = m_valid && m_src == 2'd1 && !m_done;
        e_timeout  = e_need && !rdata_valid_i && m_waited == LT;
        abort      = e_need && m_waited >= 1 && flush_i;
        e_complete = m_valid && (!e_need || rdata_valid_i) && !abort;
        e_busy     = e_need && !rdata_valid_i && !e_timeout;
        e_err      = e_timeout && !flush_i;
        e_wr       = e_complete && m_rw && m_rd != 0;
        case (m_src)
            2'd0: e_res = m_alu;
            2'd1: e_res = m_done ? m_ldata : ref_ext(m_f3, m_alu, rdata_i);
            2'd2: e_res = m_pc4;
            default: e_res = m_imm;
        endcase
        e_res_chk = m_valid && (m_src != 2'd1 || m_done || e_complete);
        chk("reg_write_w", reg_write_w, e_wr);
        chk("rd_w", rd_w, m_rd);
        chk("busy_o", busy_o, e_busy);
        chk("load_err_o", load_err_o, e_err);
        if (e_res_chk) chk("result_w", result_w, e_res);
`ifdef WB_RETIRE_CNT_EN
        chk("retire_cnt_o", retire_cnt_o, m_retired);
`endif
    endtask

    task automatic adv();
        bit capture;
        @(posedge clk);
        capture = !e_busy && !stall_i;
        if (e_complete && !m_done) m_retired++;
        if (flush_i) model_clear();
        else if (capture) begin
            m_valid = valid_m; m_rw = reg_write_m; m_src = result_src_m; m_f3 = funct3_m;
            m_alu = alu_result_m; m_pc4 = pc_plus4_m; m_imm = imm_m; m_rd = rd_m;
            m_done = 0; m_waited = 0;
        end else if (e_timeout) model_clear();
        else if (e_complete) begin
            if (!m_done) m_ldata = ref_ext(m_f3, m_alu, rdata_i);
            m_done = 1;
        end else if (e_need) m_waited++;
        @(negedge clk);
    endtask

    logic [2:0] f3_tab [8];

    initial begin
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd3, 3'd7};
        model_clear();
        @(negedge clk);
        #1;
        chk("rst_reg_write", reg_write_w, 0);
        chk("rst_rd", rd_w, 0);
        chk("rst_result", result_w, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", load_err_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ALU op
        set_m(1, 1, 2'd0, 3'd0, 32'h0000_1234, 0, 5'd5); eval(); adv();
        set_m(0, 0, 0, 0, 0, 0, 0); eval();
        chk("alu_wr", reg_write_w, 1); chk("alu_rd", rd_w, 5); chk("alu_res", result_w, 32'h1234);
        adv();

        // Pipelined LB / LBU / LHU
        rdata_i = 32'h80FF_0000; rdata_valid_i = 1;
        set_m(1, 1, 2'd1, 3'd0, 32'h0000_1003, 0, 5'd3); eval(); adv();
        set_m(1, 1, 2'd1, 3'd4, 32'h0000_1003, 0, 5'd4); eval();
        chk("lb_res", result_w, 32'hFFFF_FF80); chk("lb_wr", reg_write_w, 1);
        adv();
        set_m(1, 1, 2'd1, 3'd5, 32'h0000_1002, 0, 5'd6); eval();
        chk("lbu_res", result_w, 32'h0000_0080);
        adv();
        set_m(0, 0, 0, 0, 0, 0, 0); eval();
        chk("lhu_res", result_w, 32'h0000_80FF);
        adv();

        // Load waiting three cycles, next instruction held upstream
        rdata_valid_i = 0;
        set_m(1, 1, 2'd1, 3'd2, 32'h0000_2000, 0, 5'd9); eval(); adv();
        set_m(1, 1, 2'd0, 3'd0, 32'h0000_0055, 0, 5'd7);
        for (int i = 0; i < 3; i++) begin
            eval(); chk("wait_busy", busy_o, 1); chk("wait_wr", reg_write_w, 0); adv();
        end
        rdata_i = 32'hDEAD_BEEF; rdata_valid_i = 1; eval();
        chk("wait_done_wr", reg_write_w, 1); chk("wait_done_res", result_w, 32'hDEAD_BEEF);
        chk("wait_done_busy", busy_o, 0);
        adv();
        rdata_valid_i = 0; set_m(0, 0, 0, 0, 0, 0, 0); eval();
        chk("after_wait_rd", rd_w, 7); chk("after_wait_res", result_w, 32'h55);
        chk("after_wait_wr", reg_write_w, 1);
        adv();

        // Timeout
        set_m(1, 1, 2'd1, 3'd2, 32'h0000_3000, 0, 5'd10); eval(); adv();
        set_m(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < LT; i++) begin
            eval(); chk("to_busy", busy_o, 1); chk("to_err_early", load_err_o, 0); adv();
        end
        eval();
        chk("to_err", load_err_o, 1); chk("to_busy_drop", busy_o, 0); chk("to_wr", reg_write_w, 0);
        adv();
        eval(); chk("to_err_once", load_err_o, 0); chk("to_idle_busy", busy_o, 0); adv();

        // JAL-style with rd=0 then rd=1
        set_m(1, 1, 2'd2, 3'd0, 0, 32'h104, 5'd0); eval(); adv();
        set_m(1, 1, 2'd2, 3'd0, 0, 32'h104, 5'd1); eval();
        chk("jal_x0_wr", reg_write_w, 0); chk("jal_x0_res", result_w, 32'h104);
        adv();
        set_m(0, 0, 0, 0, 0, 0, 0); eval();
        chk("jal_x1_wr", reg_write_w, 1);
        adv();

        // Async reset in WAIT_LOAD
        set_m(1, 1, 2'd1, 3'd2, 32'h0000_4000, 0, 5'd11); eval(); adv();
        set_m(0, 0, 0, 0, 0, 0, 0); eval(); adv();
        eval();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy_o, 0); chk("arst_rd", rd_w, 0); chk("arst_res", result_w, 0);
        chk("arst_wr", reg_write_w, 0); chk("arst_err", load_err_o, 0);
        model_clear(); m_retired = 0;
        @(negedge clk);
        rst_n = 1'b1;
        eval(); chk("post_rst_busy", busy_o, 0);
`ifdef WB_RETIRE_CNT_EN
        chk("post_rst_retire", retire_cnt_o, 0);
`endif
        adv();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            valid_m       = ($urandom_range(0, 9) != 0);
            reg_write_m   = ($urandom_range(0, 3) != 0);
            result_src_m  = 2'($urandom_range(0, 3));
            funct3_m      = f3_tab[$urandom_range(0, 7)];
            alu_result_m  = $urandom;
            pc_plus4_m    = $urandom;
            imm_m         = $urandom;
            rd_m          = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rdata_i       = $urandom;
            rdata_valid_i = ($urandom_range(0, 99) < 45);
            stall_i       = ($urandom_range(0, 99) < 20);
            flush_i       = ($urandom_range(0, 99) < 4);
            eval();
            adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
